bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 137 +++++++++++++
 tb/tb_bit_serializer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Byte FIFO feeding an 8-bit parallel-to-serial shifter with hold/flush control.
// Each byte is popped on the edge that registers its first bit; the stream has no inter-byte bubble.
module bit_serializer #(
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               in_byte,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     out_bit,
  output logic                     out_valid,
  output logic                     out_sof,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);
  localparam logic [2:0]    FirstIdx  = MSB_FIRST ? 3'd7 : 3'd0;

  typedef enum logic {StIdle, StActive} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      sr_q, sr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_bit_q, out_bit_d;
  logic            out_valid_q, out_valid_d;
  logic            out_sof_q, out_sof_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      head;
  logic [2:0]      bit_idx;
  logic            push, pop;

  // in_ready depends only on registered state: no bypass when a pop frees a slot.
  assign in_ready   = (count_q != FullCount);
  assign fifo_count = count_q;
  assign out_bit    = out_bit_q;
  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_bit_d   = out_bit_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    pop         = 1'b0;
    push        = in_valid && in_ready && !flush;
    head        = mem_q[rd_ptr_q];
    bit_idx     = MSB_FIRST ? (3'd7 - cnt_q) : cnt_q;

    if (flush) begin
      state_d  = StIdle;
      cnt_d    = 3'd0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (!hold) begin
        unique case (state_q)
          StIdle: begin
            if (count_q != '0) begin
              pop         = 1'b1;
              sr_d        = head;
              out_bit_d   = head[FirstIdx];
              out_valid_d = 1'b1;
              out_sof_d   = 1'b1;
              cnt_d       = 3'd1;
              state_d     = StActive;
            end
          end
          StActive: begin
            out_bit_d   = sr_q[bit_idx];
            out_valid_d = 1'b1;
            // Returning to idle after bit 7 lets the next edge pop the following byte gap-free.
            if (cnt_q == 3'd7) begin
              cnt_d   = 3'd0;
              state_d = StIdle;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
          default: state_d = StIdle;
        endcase
      end

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      sr_q        <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
    end
  end

  // Storage needs no reset: entries are only read once count_q covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_byte;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboarded bench for bit_serializer: expected bits are queued at write time and
// popped by a negedge monitor whenever out_valid is seen.
module tb_bit_serializer;

  localparam int unsigned DEPTH     = 4;
  localparam bit          MSB_FIRST = 1'b1;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       hold;
  logic       flush;
  logic       out_bit;
  logic       out_valid;
  logic       out_sof;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q [$];   // {bit, sof}
  logic [1:0] exp_v;

  bit_serializer #(
    .DEPTH     (DEPTH),
    .MSB_FIRST (MSB_FIRST)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hold       (hold),
    .flush      (flush),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push_exp(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = MSB_FIRST ? (7 - i) : i;
      exp_q.push_back({b[idx], (i == 0) ? 1'b1 : 1'b0});
    end
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_extra: got bit=%0b sof=%0b, required no valid bit", out_bit, out_sof);
      end else begin
        exp_v = exp_q.pop_front();
        if ({out_bit, out_sof} !== exp_v)
          begin
            n_fail++;
            $display("FAIL stream_data: got bit=%0b sof=%0b, required bit=%0b sof=%0b",
                     out_bit, out_sof, exp_v[1], exp_v[0]);
          end
      end
    end
  end

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && out_valid === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    hold     = 1'b0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, out_sof, out_bit} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid/sof/bit=%b, required 000", {out_valid, out_sof, out_bit});
    end
    n_checks++;
    if (fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d, required 0", fifo_count);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 1", in_ready);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    bit to;
    @(negedge clk);
    in_byte = 8'hB0; in_valid = 1'b1; push_exp(8'hB0);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_latency: got valid=%b count=%0d, required valid=0 count=1",
               out_valid, fifo_count);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL single_run bit %0d: got valid=%b, required 1", i, out_valid);
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: got valid=%b, required 0", out_valid);
    end
    wait_idle(to);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    int first, last, nv;
    bit to;
    bytes[0] = 8'h3C; bytes[1] = 8'hE1; bytes[2] = 8'h5A; bytes[3] = 8'h0F;
    first = -1; last = -1; nv = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        nv++;
      end
      n_checks++;
      if (in_ready !== (fifo_count != 3'd4)) begin
        n_fail++;
        $display("FAIL b2b_ready cycle %0d: got in_ready=%b with count=%0d", c, in_ready, fifo_count);
      end
      if (c < 4) begin
        in_byte = bytes[c]; in_valid = 1'b1; push_exp(bytes[c]);
      end else begin
        in_valid = 1'b0;
      end
    end
    n_checks++;
    if (nv != 32 || (last - first + 1) != 32) begin
      n_fail++;
      $display("FAIL b2b_contiguous: got %0d valid over span %0d, required 32 over 32",
               nv, last - first + 1);
    end
    wait_idle(to);
  endtask

  task automatic test_hold();
    int seen;
    bit to;
    @(negedge clk);
    in_byte = 8'hA5; in_valid = 1'b1; push_exp(8'hA5);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 3) begin
      n_fail++;
      $display("FAIL hold_start: got %0d bits, required 3", seen);
    end
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || out_bit !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_stall %0d: got valid=%b bit=%b, required valid=0 bit=1",
                 h, out_valid, out_bit);
      end
    end
    hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_resume %0d: got valid=%b, required 1", i, out_valid);
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_after: got valid=%b, required 0", out_valid);
    end
    wait_idle(to);
  endtask

  task automatic test_full_pop();
    logic [7:0] ys [4];
    bit to;
    ys[0] = 8'hC3; ys[1] = 8'h69; ys[2] = 8'hF0; ys[3] = 8'h1E;
    @(negedge clk);
    in_byte = 8'h96; in_valid = 1'b1; push_exp(8'h96);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_byte = ys[k]; push_exp(ys[k]);
    end
    // Held write of 8'h77 must never be accepted, including on the pop edge.
    @(negedge clk);
    in_byte = 8'h77;
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL full_hold %0d: got count=%0d ready=%b, required count=4 ready=0",
                 j, fifo_count, in_ready);
      end
      @(negedge clk);
    end
    n_checks++;
    if (fifo_count !== 3'd3 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_edge: got count=%0d ready=%b, required count=3 ready=1",
               fifo_count, in_ready);
    end
    in_valid = 1'b0;
    wait_idle(to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL full_drain: got %0d bits pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    bit to;
    @(negedge clk); in_byte = 8'hD2; in_valid = 1'b1; push_exp(8'hD2);
    @(negedge clk); in_byte = 8'h4B; push_exp(8'h4B);
    @(negedge clk); in_byte = 8'h87; push_exp(8'h87);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_count !== 3'd2 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_setup: got count=%0d valid=%b, required count=2 valid=1",
               fifo_count, out_valid);
    end
    flush = 1'b1; in_valid = 1'b1; in_byte = 8'hFF;
    @(negedge clk);
    n_checks++;
    if (fifo_count !== 3'd0 || out_valid !== 1'b0 || out_sof !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_edge: got count=%0d valid=%b sof=%b ready=%b, required 0/0/0/1",
               fifo_count, out_valid, out_sof, in_ready);
    end
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
        n_fail++;
        $display("FAIL flush_quiet %0d: got valid=%b count=%0d, required 0/0", i, out_valid, fifo_count);
      end
    end
    @(negedge clk); in_byte = 8'h81; in_valid = 1'b1; push_exp(8'h81);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_sof !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_restart: got valid=%b sof=%b, required 1/1", out_valid, out_sof);
    end
    wait_idle(to);
  endtask

  task automatic test_reset_mid();
    bit to;
    @(negedge clk); in_byte = 8'h3E; in_valid = 1'b1; push_exp(8'h3E);
    @(negedge clk); in_byte = 8'hA9; push_exp(8'hA9);
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_sof, out_bit} !== 3'b000 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: got valid/sof/bit=%b count=%0d ready=%b, required 000/0/1",
               {out_valid, out_sof, out_bit}, fifo_count, in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_quiet %0d: got valid=%b, required 0", i, out_valid);
      end
    end
    @(negedge clk); in_byte = 8'hC7; in_valid = 1'b1; push_exp(8'hC7);
    @(negedge clk); in_valid = 1'b0;
    wait_idle(to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL reset_restart: got %0d bits pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_full_pop();
    test_flush();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d bits pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
